// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Processor-wide constants and types shared by the register
//               file, the write-back mux and the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int ADDR_WIDTH  = 3;
  localparam int NUM_REGS    = 2 ** ADDR_WIDTH;
  localparam int COUNT_WIDTH = 8;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 3'd0;

  typedef logic [DATA_WIDTH-1:0]                data_t;
  typedef logic [ADDR_WIDTH-1:0]                addr_t;
  typedef logic [COUNT_WIDTH-1:0]               count_t;
  typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_t;

  // R0 is hardwired to zero: it never stores and always reads as 0.
  function automatic logic is_zero_reg(input addr_t idx);
    return (idx == ZERO_REG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_if
// Description : Write-back and operand-read bundle between the pipeline
//               control/datapath (master) and the register file (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_if;
  import register_file_pkg::*;

  logic   reg_write;
  addr_t  write_reg;
  data_t  write_data;
  addr_t  read_reg1;
  addr_t  read_reg2;
  data_t  read_data1;
  data_t  read_data2;
  count_t write_count;

  modport master (
    output reg_write, write_reg, write_data, read_reg1, read_reg2,
    input  read_data1, read_data2, write_count
  );

  modport slave (
    input  reg_write, write_reg, write_data, read_reg1, read_reg2,
    output read_data1, read_data2, write_count
  );

endinterface
`default_nettype wire

// File: rtl/register_file_reg_read_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_port
// Description : One combinational read port: R0 zero check, write-through
//               bypass of the value about to commit, then array select.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_read_port
  import register_file_pkg::*;
(
  input  addr_t read_reg_i,
  input  regs_t regs_i,
  input  logic  bypass_en_i,
  input  addr_t write_reg_i,
  input  data_t write_data_i,
  output data_t read_data_o
);

  // Priority: R0 always zero, then the in-flight write, then stored value.
  always_comb begin
    read_data_o = '0;
    if (is_zero_reg(read_reg_i)) begin
      read_data_o = '0;
    end else if (bypass_en_i && (read_reg_i == write_reg_i)) begin
      read_data_o = write_data_i;
    end else begin
      read_data_o = regs_i[read_reg_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 8 x 16-bit register file with hardwired-zero R0, two
//               combinational read ports with write-through bypass, and a
//               wrapping count of committed writes.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
  import register_file_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  bus
);

  regs_t  regs_q;
  regs_t  regs_d;
  count_t write_count_q;
  count_t write_count_d;

  logic   commit_en;
  logic   bypass_en;
  data_t  read_data1;
  data_t  read_data2;

  // Writes to R0 are discarded and do not count as committed.
  assign commit_en = bus.reg_write && !is_zero_reg(bus.write_reg);

  // Storage is held cleared during reset, so the bypass must be too;
  // otherwise a write asserted during reset would leak onto the outputs.
  assign bypass_en = commit_en && !rst;

  // Next-state for storage and write counter.
  always_comb begin
    regs_d        = regs_q;
    write_count_d = write_count_q;
    if (commit_en) begin
      regs_d[bus.write_reg] = bus.write_data;
      write_count_d         = write_count_q + COUNT_WIDTH'(1);
    end
    regs_d[ZERO_REG] = '0;
  end

  // State register; reset clears everything without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q        <= '0;
      write_count_q <= '0;
    end else begin
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  reg_read_port u_read_port1 (
    .read_reg_i   (bus.read_reg1),
    .regs_i       (regs_q),
    .bypass_en_i  (bypass_en),
    .write_reg_i  (bus.write_reg),
    .write_data_i (bus.write_data),
    .read_data_o  (read_data1)
  );

  reg_read_port u_read_port2 (
    .read_reg_i   (bus.read_reg2),
    .regs_i       (regs_q),
    .bypass_en_i  (bypass_en),
    .write_reg_i  (bus.write_reg),
    .write_data_i (bus.write_data),
    .read_data_o  (read_data2)
  );

  assign bus.read_data1  = read_data1;
  assign bus.read_data2  = read_data2;
  assign bus.write_count = write_count_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;
  import register_file_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  register_file_if bus ();

  register_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic we, input addr_t wr, input data_t wd);
    bus.reg_write  = we;
    bus.write_reg  = wr;
    bus.write_data = wd;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive_write(1'b1, 3'd3, 16'h1111);
    bus.read_reg1 = 3'd3;
    bus.read_reg2 = 3'd3;

    // Reset state: outputs zero even with a write to the read index pending.
    #2;
    check("rst_rd1", 32'(bus.read_data1), 32'h0);
    check("rst_rd2", 32'(bus.read_data2), 32'h0);
    check("rst_cnt", 32'(bus.write_count), 32'h0);
    tick();
    // Reset dominated the write across the edge.
    drive_write(1'b0, 3'd3, 16'h0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_dominates", 32'(bus.read_data1), 32'h0);

    // Test 1: write R3=456, then asynchronous reset mid-cycle.
    drive_write(1'b1, 3'd3, 16'd456);
    tick();
    drive_write(1'b0, 3'd0, 16'h0);
    check("t1_r3", 32'(bus.read_data1), 32'd456);
    check("t1_cnt", 32'(bus.write_count), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_async_r3", 32'(bus.read_data1), 32'h0);
    check("t1_async_cnt", 32'(bus.write_count), 32'h0);
    #1;
    rst = 1'b0;

    // Test 2: basic write/read.
    drive_write(1'b1, 3'd2, 16'd123);
    tick();
    drive_write(1'b0, 3'd0, 16'h0);
    bus.read_reg1 = 3'd2;
    #1;
    check("t2_r2", 32'(bus.read_data1), 32'd123);
    check("t2_cnt1", 32'(bus.write_count), 32'd1);
    drive_write(1'b1, 3'd5, 16'd456);
    tick();
    drive_write(1'b0, 3'd0, 16'h0);
    bus.read_reg2 = 3'd5;
    #1;
    check("t2_r5", 32'(bus.read_data2), 32'd456);
    check("t2_r2_kept", 32'(bus.read_data1), 32'd123);
    check("t2_cnt2", 32'(bus.write_count), 32'd2);

    // Test 3: R0 hardwired, no bypass on R0, no count.
    drive_write(1'b1, 3'd0, 16'hFFFF);
    bus.read_reg1 = 3'd0;
    #1;
    check("t3_r0_pre", 32'(bus.read_data1), 32'h0);
    tick();
    drive_write(1'b0, 3'd0, 16'h0);
    #1;
    check("t3_r0_post", 32'(bus.read_data1), 32'h0);
    check("t3_cnt", 32'(bus.write_count), 32'd2);

    // Test 4: bypass on both ports.
    drive_write(1'b1, 3'd4, 16'd123);
    tick();
    drive_write(1'b1, 3'd4, 16'd456);
    bus.read_reg1 = 3'd4;
    bus.read_reg2 = 3'd4;
    #1;
    check("t4_byp_rd1", 32'(bus.read_data1), 32'd456);
    check("t4_byp_rd2", 32'(bus.read_data2), 32'd456);
    tick();
    drive_write(1'b0, 3'd4, 16'h0);
    #1;
    check("t4_post_rd1", 32'(bus.read_data1), 32'd456);
    check("t4_post_rd2", 32'(bus.read_data2), 32'd456);
    check("t4_cnt", 32'(bus.write_count), 32'd4);
    // Bypass on one port only; write withdrawn before the edge.
    drive_write(1'b1, 3'd2, 16'hBEEF);
    bus.read_reg1 = 3'd2;
    bus.read_reg2 = 3'd4;
    #1;
    check("t4_one_byp", 32'(bus.read_data1), 32'hBEEF);
    check("t4_other_port", 32'(bus.read_data2), 32'd456);
    drive_write(1'b0, 3'd2, 16'hBEEF);
    #1;
    check("t4_no_byp_when_off", 32'(bus.read_data1), 32'd123);

    // Test 5: write disable.
    drive_write(1'b0, 3'd6, 16'd789);
    bus.read_reg1 = 3'd6;
    #1;
    check("t5_pre", 32'(bus.read_data1), 32'h0);
    tick();
    #1;
    check("t5_post", 32'(bus.read_data1), 32'h0);
    check("t5_cnt", 32'(bus.write_count), 32'd4);

    // Test 6: counter wrap from a clean reset.
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.read_reg1 = 3'd1;
    bus.read_reg2 = 3'd2;
    for (int i = 0; i < 256; i++) begin
      drive_write(1'b1, 3'd1, i[15:0]);
      tick();
      if (i == 254) begin
        check("t6_cnt_255", 32'(bus.write_count), 32'd255);
      end
    end
    drive_write(1'b0, 3'd1, 16'h0);
    #1;
    check("t6_cnt_wrap", 32'(bus.write_count), 32'd0);
    check("t6_r1", 32'(bus.read_data1), 32'd255);
    check("t6_r2_clear", 32'(bus.read_data2), 32'd0);

    // Full-width storage.
    drive_write(1'b1, 3'd7, 16'h8001);
    tick();
    drive_write(1'b0, 3'd0, 16'h0);
    bus.read_reg2 = 3'd7;
    #1;
    check("fullwidth_r7", 32'(bus.read_data2), 32'h8001);
    check("fullwidth_cnt", 32'(bus.write_count), 32'd1);

    // X on write_data with writes disabled leaves state intact.
    bus.reg_write  = 1'b0;
    bus.write_reg  = 3'd1;
    bus.write_data = 'x;
    tick();
    #1;
    check("x_data_r1", 32'(bus.read_data1), 32'd255);
    check("x_data_cnt", 32'(bus.write_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- 16-bit general-purpose register file for the RISC processor.
- Sits directly downstream of the write-back 2-to-1 mux (ALU result vs. memory data).
- Consumes the mux output as write data and stores it into the selected register on the clock edge.
- Supplies two combinational read operands to the ALU/decode stage, with write-through bypass and a hardwired-zero R0.

Parameters:
DATA_WIDTH, 16, width of each register and of the data ports
ADDR_WIDTH, 3, register index width; NUM_REGS = 2**ADDR_WIDTH (8 registers)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
reg_write  input  1  write enable from control unit
write_reg  input  ADDR_WIDTH  destination register index
write_data  input  DATA_WIDTH  write-back value (output of write-back mux)
read_reg1  input  ADDR_WIDTH  source register index, port 1
read_reg2  input  ADDR_WIDTH  source register index, port 2
read_data1  output  DATA_WIDTH  operand 1
read_data2  output  DATA_WIDTH  operand 2
write_count  output  8  number of committed writes since reset, wraps 255->0 (debug/verification)

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset:
  - rst high clears all registers R0..R7 to 0 and write_count to 0 immediately, without waiting for clk.
  - Reset dominates any concurrent write.
  - A write in flight when rst asserts is lost.
  - On rst deassertion, the first write takes effect on the next rising clk edge.
- Write:
  - On rising clk with reg_write=1 and write_reg!=0, R[write_reg] <= write_data.
  - write_count increments by 1, modulo 256.
  - reg_write=0: no register changes, no count.
  - write_reg=0: the write is discarded, R0 stays 0, write_count does not increment.
- Read:
  - Combinational, zero-cycle latency.
  - read_dataN = 0 when read_regN=0.
  - Otherwise read_dataN = R[read_regN], subject to the bypass rule below.
- Bypass (write-through):
  - If reg_write=1, write_reg!=0 and read_regN==write_reg in the same cycle, read_dataN = write_data (the value about to commit), not the stale register.
  - The rule applies independently to both ports.
  - Both ports may hit the bypass simultaneously.
- Same index on both read ports: both outputs return identical values.
- Write data is stored full-width: no sign extension or truncation.
- X on write_data with reg_write=0 must not corrupt state.
- Outputs during reset: read_data1/2 = 0 for all indices; write_count = 0.
- No stall or handshake. Exactly one write per cycle maximum.

Decomposition:
- Shared package (processor defines header): DATA_WIDTH=16, ADDR_WIDTH=3, NUM_REGS=8, ZERO_REG=3'd0.
  - The write-back mux and ALU use the same constants.
- One natural sub-module: reg_read_port. It holds the combinational zero-check + bypass + array select, instantiated twice (ports 1 and 2).
- Storage array, write logic and write_count stay in the top.

Test Plan:
1. Reset: pulse rst mid-cycle after writing R3=456 -> R3 reads 0 immediately (before next clk edge); write_count=0.
2. Basic write/read: reg_write=1, write_reg=2, write_data=123, one clk -> read_reg1=2 gives 123; write_count=1. Then write R5=456 -> read_reg2=5 gives 456, read_reg1=2 still 123.
3. R0 hardwired: reg_write=1, write_reg=0, write_data=16'hFFFF, clk -> read_reg1=0 gives 0; write_count unchanged.
4. Bypass: R4 holds 123; same cycle reg_write=1, write_reg=4, write_data=456, read_reg1=read_reg2=4 -> both outputs 456 before the edge, still 456 after the edge with reg_write=0.
5. Write disable: reg_write=0, write_reg=6, write_data=789, clk -> R6 remains 0; no bypass (read_reg1=6 gives 0).
6. Counter wrap: 256 consecutive writes to R1 with incrementing data 0..255 -> write_count returns to 0; R1=255; overflow has no effect on register contents.
